// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the register file and its multdiv scoreboard.
package regfile_scoreboard_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int DEFAULT_MD_TIMEOUT = 64;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam logic [4:0] REG_RSTATUS = 5'd30;
    localparam logic [4:0] REG_RA      = 5'd31;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sb_state_e;

endpackage

// File: rtl/regfile_scoreboard_md_scoreboard.sv
// Tracks the single outstanding multdiv destination, raises decode stalls on
// RAW hazards against it, and clears itself if the result never arrives.
module md_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int MD_TIMEOUT = DEFAULT_MD_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  md_issue,
    input  logic [ADDR_WIDTH-1:0] md_rd,
    input  logic                  md_rdy,
    input  logic [ADDR_WIDTH-1:0] rd_a,
    input  logic [ADDR_WIDTH-1:0] rd_b,
    output logic                  hazard_stall,
    output logic                  md_busy,
    output logic                  md_timeout
);

    localparam int CNT_W = $clog2(MD_TIMEOUT);
    localparam logic [CNT_W-1:0]      WD_LAST  = CNT_W'(MD_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

    sb_state_e             state_r;
    logic [ADDR_WIDTH-1:0] pend_rd_r;
    logic [CNT_W-1:0]      wd_cnt_r;
    logic                  md_timeout_r;
    logic                  track_issue_s;
    logic                  rd_match_s;

    assign track_issue_s = md_issue && (md_rd != ZERO_IDX);

    // Scoreboard FSM with pending destination and watchdog counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            pend_rd_r    <= ZERO_IDX;
            wd_cnt_r     <= '0;
            md_timeout_r <= 1'b0;
        end else begin
            md_timeout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (track_issue_s) begin
                        state_r   <= BUSY;
                        pend_rd_r <= md_rd;
                        wd_cnt_r  <= '0;
                    end
                end
                BUSY: begin
                    if (md_rdy) begin
                        // Back-to-back multdiv: retire the old one and track the new one.
                        if (track_issue_s) begin
                            pend_rd_r <= md_rd;
                            wd_cnt_r  <= '0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (wd_cnt_r == WD_LAST) begin
                        state_r      <= IDLE;
                        md_timeout_r <= 1'b1;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Hazard detection against the pending destination.
    always_comb begin
        rd_match_s   = (rd_a == pend_rd_r) || (rd_b == pend_rd_r);
        md_busy      = (state_r == BUSY);
        hazard_stall = 1'b0;
        if ((state_r == BUSY) && !md_rdy) begin
            hazard_stall = rd_match_s;
        end else begin
            hazard_stall = 1'b0;
        end
    end

    assign md_timeout = md_timeout_r;

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with write-to-read bypass and a multdiv
// scoreboard for decode-stage RAW stalls.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int MD_TIMEOUT = DEFAULT_MD_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    input  logic                  md_issue,
    input  logic [ADDR_WIDTH-1:0] md_rd,
    input  logic                  md_RDY,
    output logic                  hazard_stall,
    output logic                  md_busy,
    output logic                  md_timeout
);

    localparam int NREGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] mem_r [0:NREGS-1];

    // Read-port mux: zero register, bypass of the in-flight write, then storage.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic                  rst_active,
        input logic [ADDR_WIDTH-1:0] idx,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  we,
        input logic [ADDR_WIDTH-1:0] wreg,
        input logic [DATA_WIDTH-1:0] wdata
    );
        logic [DATA_WIDTH-1:0] val;
        val = '0;
        if (rst_active || (idx == ZERO_IDX)) begin
            val = '0;
        end else if (we && (wreg == idx)) begin
            val = wdata;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Register storage; index 0 is never written so it stays zero.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_r[i] <= '0;
            end
        end else if (ctrl_writeEnable && (ctrl_writeReg != ZERO_IDX)) begin
            mem_r[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Combinational operand reads.
    always_comb begin
        data_readRegA = read_port(!ctrl_reset_n, ctrl_readRegA, mem_r[ctrl_readRegA],
                                  ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        data_readRegB = read_port(!ctrl_reset_n, ctrl_readRegB, mem_r[ctrl_readRegB],
                                  ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end

    md_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MD_TIMEOUT (MD_TIMEOUT)
    ) u_md_scoreboard (
        .clk          (clock),
        .rst_n        (ctrl_reset_n),
        .md_issue     (md_issue),
        .md_rd        (md_rd),
        .md_rdy       (md_RDY),
        .rd_a         (ctrl_readRegA),
        .rd_b         (ctrl_readRegB),
        .hazard_stall (hazard_stall),
        .md_busy      (md_busy),
        .md_timeout   (md_timeout)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: table-driven cycle vectors through a scoreboard queue,
// plus a hand-written asynchronous reset sequence.
module tb_regfile_scoreboard;

    logic        clock = 1'b0;
    logic        ctrl_reset_n;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        md_issue;
    logic [4:0]  md_rd;
    logic        md_RDY;
    logic        hazard_stall;
    logic        md_busy;
    logic        md_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        issue;
        logic [4:0]  rd;
        logic        rdy;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_stall;
        logic        exp_busy;
        logic        exp_tmo;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic        stall;
        logic        busy;
        logic        tmo;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    regfile_scoreboard #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .MD_TIMEOUT (8)
    ) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .md_issue         (md_issue),
        .md_rd            (md_rd),
        .md_RDY           (md_RDY),
        .hazard_stall     (hazard_stall),
        .md_busy          (md_busy),
        .md_timeout       (md_timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t v(input logic we, input logic [4:0] wreg, input logic [31:0] wd,
                               input logic [4:0] ra, input logic [4:0] rb,
                               input logic issue, input logic [4:0] rd, input logic rdy,
                               input logic [31:0] ea, input logic [31:0] eb,
                               input logic es, input logic ebusy, input logic et);
        vec_t r;
        r.we = we; r.wreg = wreg; r.wd = wd; r.ra = ra; r.rb = rb;
        r.issue = issue; r.rd = rd; r.rdy = rdy;
        r.exp_a = ea; r.exp_b = eb; r.exp_stall = es; r.exp_busy = ebusy; r.exp_tmo = et;
        return r;
    endfunction

    task automatic drive(input vec_t x);
        ctrl_writeEnable = x.we;
        ctrl_writeReg    = x.wreg;
        data_writeReg    = x.wd;
        ctrl_readRegA    = x.ra;
        ctrl_readRegB    = x.rb;
        md_issue         = x.issue;
        md_rd            = x.rd;
        md_RDY           = x.rdy;
    endtask

    task automatic check_outputs(input int idx, input logic [31:0] a, input logic [31:0] b,
                                 input logic stall, input logic busy, input logic tmo);
        chk("read_a", idx, data_readRegA, a);
        chk("read_b", idx, data_readRegB, b);
        chk("hazard_stall", idx, {31'd0, hazard_stall}, {31'd0, stall});
        chk("md_busy", idx, {31'd0, md_busy}, {31'd0, busy});
        chk("md_timeout", idx, {31'd0, md_timeout}, {31'd0, tmo});
    endtask

    initial begin
        exp_t e;
        vec_t idle;
        idle = v(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Basic writes, r0 immunity, bypass to port B.
        vecs.push_back(v(1'b1, 5'd5,  32'h1234_5678, 5'd5, 5'd0,  1'b0, 5'd0, 1'b0, 32'h1234_5678, 32'd0,         1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 5'd0,  32'd0,         5'd5, 5'd5,  1'b0, 5'd0, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0, 5'd0,  1'b0, 5'd0, 1'b0, 32'd0,         32'd0,         1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 5'd0,  32'd0,         5'd0, 5'd5,  1'b0, 5'd0, 1'b0, 32'd0,         32'h1234_5678, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b1, 5'd31, 32'hDEAD_BEEF, 5'd5, 5'd31, 1'b0, 5'd0, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 5'd0,  32'd0,         5'd31,5'd31, 1'b0, 5'd0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0));
        // Multdiv to r7: stall from the next cycle, retire with writeback of 42.
        vecs.push_back(v(1'b0, 5'd0,  32'd0,         5'd7, 5'd0,  1'b1, 5'd7, 1'b0, 32'd0,  32'd0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(v(1'b0, 5'd0, 32'd0,      5'd7, 5'd0,  1'b0, 5'd0, 1'b0, 32'd0,  32'd0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(v(1'b1, 5'd7,  32'd42,        5'd7, 5'd0,  1'b0, 5'd0, 1'b1, 32'd42, 32'd0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(v(1'b0, 5'd0,  32'd0,         5'd7, 5'd0,  1'b0, 5'd0, 1'b0, 32'd42, 32'd0, 1'b0, 1'b0, 1'b0));
        // Retire r7 and issue r9 in the same cycle.
        vecs.push_back(v(1'b0, 5'd0,  32'd0,         5'd0, 5'd0,  1'b1, 5'd7, 1'b0, 32'd0,   32'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b1, 5'd7,  32'd100,       5'd7, 5'd9,  1'b1, 5'd9, 1'b1, 32'd100, 32'd0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(v(1'b0, 5'd0,  32'd0,         5'd7, 5'd0,  1'b0, 5'd0, 1'b0, 32'd100, 32'd0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(v(1'b0, 5'd0,  32'd0,         5'd9, 5'd0,  1'b0, 5'd0, 1'b0, 32'd0,   32'd0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(v(1'b1, 5'd9,  32'h99,        5'd9, 5'd0,  1'b0, 5'd0, 1'b1, 32'h99,  32'd0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(v(1'b0, 5'd0,  32'd0,         5'd9, 5'd0,  1'b0, 5'd0, 1'b0, 32'h99,  32'd0, 1'b0, 1'b0, 1'b0));
        // Issue to r0 is not tracked.
        vecs.push_back(v(1'b0, 5'd0,  32'd0,         5'd0, 5'd0,  1'b1, 5'd0, 1'b0, 32'd0, 32'd0,  1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 5'd0,  32'd0,         5'd0, 5'd9,  1'b0, 5'd0, 1'b0, 32'd0, 32'h99, 1'b0, 1'b0, 1'b0));
        // Watchdog: issue r3 at edge 0, never ready; extra issue while busy is ignored.
        vecs.push_back(v(1'b0, 5'd0,  32'd0,         5'd3, 5'd0,  1'b1, 5'd3, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 5'd0,  32'd0,         5'd3, 5'd0,  1'b1, 5'd4, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(v(1'b0, 5'd0,  32'd0,         5'd4, 5'd0,  1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 6; i++)
            vecs.push_back(v(1'b0, 5'd0, 32'd0,      5'd3, 5'd0,  1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(v(1'b0, 5'd0,  32'd0,         5'd3, 5'd0,  1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(v(1'b0, 5'd0,  32'd0,         5'd3, 5'd0,  1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0));

        // Reset: outputs forced low even with a write strobe present.
        drive(v(1'b1, 5'd5, 32'hCAFE_F00D, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
        ctrl_reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_outputs(-1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        drive(idle);
        @(negedge clock);
        ctrl_reset_n = 1'b1;

        // Table: push expectations when driving, pop and compare mid-cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clock);
            #1;
            drive(vecs[i]);
            e.idx = i; e.a = vecs[i].exp_a; e.b = vecs[i].exp_b;
            e.stall = vecs[i].exp_stall; e.busy = vecs[i].exp_busy; e.tmo = vecs[i].exp_tmo;
            sb_q.push_back(e);
            @(negedge clock);
            if (sb_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL scoreboard_empty[%0d]: got 0 entries expected 1", i);
            end else begin
                e = sb_q.pop_front();
                check_outputs(e.idx, e.a, e.b, e.stall, e.busy, e.tmo);
            end
        end

        // Reset mid-BUSY with r4 = 9 stored.
        @(posedge clock);
        #1;
        drive(v(1'b1, 5'd4, 32'd9, 5'd4, 5'd0, 1'b1, 5'd4, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
        @(posedge clock);
        #1;
        drive(v(1'b0, 5'd0, 32'd0, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clock);
        check_outputs(100, 32'd9, 32'd0, 1'b1, 1'b1, 1'b0);
        #1;
        ctrl_reset_n = 1'b0;
        #1;
        check_outputs(101, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_outputs(102, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        if (sb_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
